// File: rtl/operand_exec_seq.sv
// operand_exec_seq
// Sequencer that sits behind an 8x16 register file with one combinational
// read port and one write port.
// It fetches Rn and then Rm into operand registers A and B over two cycles.
// It computes the ALU result into C and updates the {V,N,Z} flags.
// It then writes C back to Rd.
// Sequence: IDLE -> RDA -> RDB -> EXE -> WB -> IDLE.
// Throughput is one instruction every five cycles.
module operand_exec_seq #(
    parameter int W  = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [RW-1:0] rd,
    input  logic [RW-1:0] rn,
    input  logic [RW-1:0] rm,
    input  logic [W-1:0]  rf_data_out,
    output logic [RW-1:0] rf_readnum,
    output logic [RW-1:0] rf_writenum,
    output logic          rf_write,
    output logic [W-1:0]  rf_data_in,
    output logic [W-1:0]  result,
    output logic [2:0]    status,
    output logic          busy,
    output logic          done
);

    // Opcode encoding
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_EXE  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    // Signed overflow of a + b: operands agree in sign, sum does not.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                          input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Signed overflow of a - b: operands differ in sign, result sign differs from a.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                          input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

    // Pack the {V,N,Z} status word for a result.
    function automatic logic [2:0] pack_flags(input logic v, input logic [W-1:0] res);
        return {v, res[W-1], (res == {W{1'b0}})};
    endfunction

    // Sequencer state
    state_t        state_q;

    // Fields latched when a request is accepted
    logic [1:0]    op_q;
    logic [RW-1:0] rd_q;
    logic [RW-1:0] rn_q;
    logic [RW-1:0] rm_q;

    // Operand registers and the result register
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  c_q;
    logic [2:0]    status_q;

    // Registered port-side controls
    logic [RW-1:0] readnum_q;
    logic          write_q;
    logic          busy_q;
    logic          done_q;

    // ALU next values for the EXE cycle
    logic [W-1:0]  alu_res_d;
    logic          alu_v_d;
    logic [2:0]    flags_d;

    // ALU: combinational result and overflow from A, B and the latched opcode
    always_comb begin
        alu_res_d = {W{1'b0}};
        alu_v_d   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res_d = a_q + b_q;
                alu_v_d   = add_overflow(a_q[W-1], b_q[W-1], alu_res_d[W-1]);
            end
            OP_CMP: begin
                alu_res_d = a_q - b_q;
                alu_v_d   = sub_overflow(a_q[W-1], b_q[W-1], alu_res_d[W-1]);
            end
            OP_AND: begin
                alu_res_d = a_q & b_q;
                alu_v_d   = 1'b0;
            end
            OP_MVN: begin
                alu_res_d = ~b_q;
                alu_v_d   = 1'b0;
            end
            default: begin
                alu_res_d = {W{1'b0}};
                alu_v_d   = 1'b0;
            end
        endcase
        flags_d = pack_flags(alu_v_d, alu_res_d);
    end

    // Sequencer FSM with all datapath registers and registered controls
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= 2'b00;
            rd_q      <= {RW{1'b0}};
            rn_q      <= {RW{1'b0}};
            rm_q      <= {RW{1'b0}};
            a_q       <= {W{1'b0}};
            b_q       <= {W{1'b0}};
            c_q       <= {W{1'b0}};
            status_q  <= 3'b000;
            readnum_q <= {RW{1'b0}};
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q  <= 1'b0;
                    write_q <= 1'b0;
                    if (start) begin
                        op_q      <= op;
                        rd_q      <= rd;
                        rn_q      <= rn;
                        rm_q      <= rm;
                        // Present Rn on the read port for the whole RDA cycle.
                        readnum_q <= rn;
                        busy_q    <= 1'b1;
                        state_q   <= S_RDA;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RDA: begin
                    a_q       <= rf_data_out;
                    readnum_q <= rm_q;
                    state_q   <= S_RDB;
                end
                S_RDB: begin
                    b_q     <= rf_data_out;
                    state_q <= S_EXE;
                end
                S_EXE: begin
                    c_q      <= alu_res_d;
                    status_q <= flags_d;
                    // CMP only sets flags; it never writes back.
                    write_q  <= (op_q != OP_CMP);
                    state_q  <= S_WB;
                end
                S_WB: begin
                    write_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    write_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // A write-back is masked while reset is asserted.
    // This keeps the regfile from capturing on a reset edge.
    assign rf_write    = write_q & reset_n;
    assign rf_writenum = rd_q;
    assign rf_readnum  = readnum_q;
    assign rf_data_in  = c_q;
    assign result      = c_q;
    assign status      = status_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
